// File: rtl/piso_serializer.sv
// Parallel-in / serial-out serializer.
// A WIDTH-bit word is accepted over a valid/ready handshake and sent one bit
// per clock on sout, qualified by sout_valid. The next word can be accepted
// during the last-bit cycle, so back-to-back words leave no gap on the line.

module piso_serializer #(
  parameter int WIDTH      = 8,
  parameter bit MSB_FIRST  = 1'b1,
  parameter bit IDLE_LEVEL = 1'b0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] load_data,
  input  logic             load_valid,
  output logic             load_ready,
  output logic             sout,
  output logic             sout_valid,
  output logic             busy,
  output logic             done
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  state_t           state;
  state_t           state_next;
  logic [WIDTH-1:0] shreg;
  logic [WIDTH-1:0] shreg_next;
  logic [CW-1:0]    count;
  logic [CW-1:0]    count_next;
  logic [CW-1:0]    count_plus;
  logic             sout_next;
  logic             sout_valid_next;
  logic             done_next;
  logic             last_bit;
  logic             accept;

  // Bit that goes out first when a fresh word is loaded.
  function automatic logic first_bit(input logic [WIDTH-1:0] word);
    return MSB_FIRST ? word[WIDTH-1] : word[0];
  endfunction

  // Bit that follows the one currently on sout, read before the shift.
  function automatic logic following_bit(input logic [WIDTH-1:0] word);
    return MSB_FIRST ? word[WIDTH-2] : word[1];
  endfunction

  // Move the register one place so the sent bit drops out of the active end.
  function automatic logic [WIDTH-1:0] shifted(input logic [WIDTH-1:0] word);
    return MSB_FIRST ? (word << 1) : (word >> 1);
  endfunction

  assign last_bit   = (state == SHIFT) && (count == LAST);
  assign load_ready = !rst && ((state == IDLE) || last_bit);
  assign accept     = load_valid && load_ready;
  assign busy       = (state == SHIFT);
  assign count_plus = count + 1'b1;

  // State, datapath and registered outputs; reset is asynchronous so an
  // in-flight word is dropped immediately and never reports done.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      shreg      <= '0;
      count      <= '0;
      sout       <= IDLE_LEVEL;
      sout_valid <= 1'b0;
      done       <= 1'b0;
    end else begin
      state      <= state_next;
      shreg      <= shreg_next;
      count      <= count_next;
      sout       <= sout_next;
      sout_valid <= sout_valid_next;
      done       <= done_next;
    end
  end

  // Next-state and next-output selection: load on accept, otherwise shift
  // until the last bit, then fall back to idle.
  always_comb begin
    state_next      = state;
    shreg_next      = shreg;
    count_next      = count;
    sout_next       = IDLE_LEVEL;
    sout_valid_next = 1'b0;
    done_next       = 1'b0;

    case (state)
      IDLE: begin
        if (accept) begin
          state_next      = SHIFT;
          shreg_next      = load_data;
          count_next      = '0;
          sout_next       = first_bit(load_data);
          sout_valid_next = 1'b1;
        end
      end

      SHIFT: begin
        if (!last_bit) begin
          shreg_next      = shifted(shreg);
          count_next      = count_plus;
          sout_next       = following_bit(shreg);
          sout_valid_next = 1'b1;
          done_next       = (count_plus == LAST);
        end else if (accept) begin
          shreg_next      = load_data;
          count_next      = '0;
          sout_next       = first_bit(load_data);
          sout_valid_next = 1'b1;
        end else begin
          state_next = IDLE;
          count_next = '0;
        end
      end

      default: begin
        state_next = IDLE;
        count_next = '0;
      end
    endcase
  end

endmodule

// File: tb/tb_piso_serializer.sv
// Testbench for piso_serializer: three instances (MSB-first, LSB-first,
// and a 2-bit idle-high corner) checked against a queue-of-bits model every
// cycle, plus directed literal checks of the serial streams.

module tb_piso_serializer;

  logic       clk = 1'b0;
  logic       rst;

  logic [7:0] data_m, data_l;
  logic [1:0] data_n;
  logic       valid_m, valid_l, valid_n;
  logic       ready_m, ready_l, ready_n;
  logic       sout_m, sout_l, sout_n;
  logic       sv_m, sv_l, sv_n;
  logic       busy_m, busy_l, busy_n;
  logic       done_m, done_l, done_n;

  int checks = 0;
  int errors = 0;

  // Expected serial stream per instance: each entry is {bit, done}; entry 0
  // is what must be on the line during the current cycle.
  logic [1:0] q_m[$];
  logic [1:0] q_l[$];
  logic [1:0] q_n[$];
  bit         acc_m, acc_l, acc_n;

  logic [31:0] b0, v0, b1, v1;
  int          d0, r0, d1, r1;

  piso_serializer #(.WIDTH(8), .MSB_FIRST(1'b1), .IDLE_LEVEL(1'b0)) dut_m (
    .clk(clk), .rst(rst), .load_data(data_m), .load_valid(valid_m),
    .load_ready(ready_m), .sout(sout_m), .sout_valid(sv_m), .busy(busy_m),
    .done(done_m)
  );

  piso_serializer #(.WIDTH(8), .MSB_FIRST(1'b0), .IDLE_LEVEL(1'b0)) dut_l (
    .clk(clk), .rst(rst), .load_data(data_l), .load_valid(valid_l),
    .load_ready(ready_l), .sout(sout_l), .sout_valid(sv_l), .busy(busy_l),
    .done(done_l)
  );

  piso_serializer #(.WIDTH(2), .MSB_FIRST(1'b1), .IDLE_LEVEL(1'b1)) dut_n (
    .clk(clk), .rst(rst), .load_data(data_n), .load_valid(valid_n),
    .load_ready(ready_n), .sout(sout_n), .sout_valid(sv_n), .busy(busy_n),
    .done(done_n)
  );

  always #5 clk = ~clk;

  function automatic logic bit_at(input logic [7:0] word, input int width,
                                  input bit msb, input int k);
    int idx = msb ? (width - 1 - k) : k;
    return word[idx];
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s actual=%0h required=%0h at %0t", name, actual,
               expected, $time);
    end
  endtask

  task automatic check_unit(input string tag, input int size,
                            input logic [1:0] head, input logic idle,
                            input logic so, input logic sv, input logic bz,
                            input logic dn, input logic rdy);
    checkOutput({tag, "_sout"}, 32'(so), 32'((size > 0) ? head[1] : idle));
    checkOutput({tag, "_valid"}, 32'(sv), 32'(size > 0));
    checkOutput({tag, "_done"}, 32'(dn), 32'((size > 0) ? head[0] : 1'b0));
    checkOutput({tag, "_busy"}, 32'(bz), 32'(size > 0));
    checkOutput({tag, "_ready"}, 32'(rdy), 32'(!rst && (size <= 1)));
  endtask

  // Model: a word is accepted when valid is high and at most the current
  // bit remains; its bits are then appended behind the current one.
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      q_m.delete();
      q_l.delete();
      q_n.delete();
    end else begin
      acc_m = valid_m && (q_m.size() <= 1);
      acc_l = valid_l && (q_l.size() <= 1);
      acc_n = valid_n && (q_n.size() <= 1);
      if (q_m.size() > 0) void'(q_m.pop_front());
      if (q_l.size() > 0) void'(q_l.pop_front());
      if (q_n.size() > 0) void'(q_n.pop_front());
      for (int k = 0; k < 8; k++) begin
        if (acc_m) q_m.push_back({bit_at(data_m, 8, 1'b1, k), k == 7});
        if (acc_l) q_l.push_back({bit_at(data_l, 8, 1'b0, k), k == 7});
      end
      for (int k = 0; k < 2; k++)
        if (acc_n) q_n.push_back({bit_at({6'b0, data_n}, 2, 1'b1, k), k == 1});
    end
  end

  // Compare every DUT output against the model on each falling edge.
  always @(negedge clk) begin
    check_unit("m", q_m.size(), (q_m.size() > 0) ? q_m[0] : 2'b00, 1'b0,
               sout_m, sv_m, busy_m, done_m, ready_m);
    check_unit("l", q_l.size(), (q_l.size() > 0) ? q_l[0] : 2'b00, 1'b0,
               sout_l, sv_l, busy_l, done_l, ready_l);
    check_unit("n", q_n.size(), (q_n.size() > 0) ? q_n[0] : 2'b00, 1'b1,
               sout_n, sv_n, busy_n, done_n, ready_n);
  end

  task automatic applyStimulus(input int sel, input logic v,
                               input logic [7:0] d);
    case (sel)
      0:       begin valid_m = v; data_m = d;      end
      1:       begin valid_l = v; data_l = d;      end
      default: begin valid_n = v; data_n = d[1:0]; end
    endcase
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Record n falling-edge samples of one instance's serial outputs.
  task automatic capture(input int sel, input int n, output logic [31:0] bits,
                         output logic [31:0] valids, output int dones,
                         output int readies);
    bits = '0; valids = '0; dones = 0; readies = 0;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      case (sel)
        0: begin
          bits = {bits[30:0], sout_m}; valids = {valids[30:0], sv_m};
          dones += int'(done_m); readies += int'(ready_m);
        end
        1: begin
          bits = {bits[30:0], sout_l}; valids = {valids[30:0], sv_l};
          dones += int'(done_l); readies += int'(ready_l);
        end
        default: begin
          bits = {bits[30:0], sout_n}; valids = {valids[30:0], sv_n};
          dones += int'(done_n); readies += int'(ready_n);
        end
      endcase
    end
  endtask

  // Directed sequence.
  initial begin
    rst = 1'b1;
    applyStimulus(0, 1'b0, 8'h00);
    applyStimulus(1, 1'b0, 8'h00);
    applyStimulus(2, 1'b0, 8'h00);
    step(3);
    rst = 1'b0;
    step(1);
    checkOutput("reset_ready_m", 32'(ready_m), 32'd1);
    checkOutput("reset_sout_m", 32'(sout_m), 32'd0);
    checkOutput("reset_sout_n", 32'(sout_n), 32'd1);
    checkOutput("reset_valid_n", 32'(sv_n), 32'd0);

    // A5 on both bit orders; trailing sample shows the idle level.
    applyStimulus(0, 1'b1, 8'hA5);
    applyStimulus(1, 1'b1, 8'hA5);
    @(posedge clk); #1;
    applyStimulus(0, 1'b0, 8'h00);
    applyStimulus(1, 1'b0, 8'h00);
    fork
      capture(0, 9, b0, v0, d0, r0);
      capture(1, 9, b1, v1, d1, r1);
    join
    checkOutput("a5_bits_m", b0, 32'h14A);
    checkOutput("a5_valid_m", v0, 32'h1FE);
    checkOutput("a5_done_m", 32'(d0), 32'd1);
    checkOutput("a5_bits_l", b1, 32'h14A);
    checkOutput("a5_done_l", 32'(d1), 32'd1);

    // 0F distinguishes the two bit orders.
    step(1);
    applyStimulus(0, 1'b1, 8'h0F);
    applyStimulus(1, 1'b1, 8'h0F);
    @(posedge clk); #1;
    applyStimulus(0, 1'b0, 8'h00);
    applyStimulus(1, 1'b0, 8'h00);
    fork
      capture(0, 8, b0, v0, d0, r0);
      capture(1, 8, b1, v1, d1, r1);
    join
    checkOutput("0f_bits_m", b0, 32'h0F);
    checkOutput("0f_bits_l", b1, 32'hF0);

    // Back-to-back A5 then 3C with valid held high.
    step(2);
    applyStimulus(0, 1'b1, 8'hA5);
    @(posedge clk); #1;
    applyStimulus(0, 1'b1, 8'h3C);
    fork
      capture(0, 17, b0, v0, d0, r0);
      begin
        repeat (8) @(posedge clk);
        #1;
        applyStimulus(0, 1'b0, 8'h00);
      end
    join
    checkOutput("b2b_bits", b0, 32'h14A78);
    checkOutput("b2b_valid", v0, 32'h1FFFE);
    checkOutput("b2b_done", 32'(d0), 32'd2);
    checkOutput("b2b_ready", 32'(r0), 32'd3);

    // FF offered mid-word waits for the last-bit cycle.
    step(2);
    applyStimulus(0, 1'b1, 8'hA5);
    @(posedge clk); #1;
    applyStimulus(0, 1'b0, 8'h00);
    fork
      capture(0, 17, b0, v0, d0, r0);
      begin
        @(posedge clk); #1;
        applyStimulus(0, 1'b1, 8'hFF);
        repeat (7) @(posedge clk);
        #1;
        applyStimulus(0, 1'b0, 8'h00);
      end
    join
    checkOutput("hold_bits", b0, 32'h14BFE);
    checkOutput("hold_done", 32'(d0), 32'd2);
    checkOutput("hold_ready", 32'(r0), 32'd3);

    // Reset during bit 3 of A5 aborts the word at once.
    step(2);
    applyStimulus(0, 1'b1, 8'hA5);
    @(posedge clk); #1;
    applyStimulus(0, 1'b0, 8'h00);
    step(2);
    #1;
    rst = 1'b1;
    #1;
    checkOutput("abort_sout", 32'(sout_m), 32'd0);
    checkOutput("abort_valid", 32'(sv_m), 32'd0);
    checkOutput("abort_busy", 32'(busy_m), 32'd0);
    checkOutput("abort_done", 32'(done_m), 32'd0);
    checkOutput("abort_ready", 32'(ready_m), 32'd0);
    step(1);
    rst = 1'b0;
    capture(0, 10, b0, v0, d0, r0);
    checkOutput("abort_after_valid", v0, 32'h0);
    checkOutput("abort_after_done", 32'(d0), 32'd0);

    // Two-bit corner, idle-high line.
    step(1);
    applyStimulus(2, 1'b1, 8'h02);
    @(posedge clk); #1;
    applyStimulus(2, 1'b0, 8'h00);
    capture(2, 3, b0, v0, d0, r0);
    checkOutput("w2_bits", b0, 32'h5);
    checkOutput("w2_valid", v0, 32'h6);
    checkOutput("w2_done", 32'(d0), 32'd1);

    step(1);
    applyStimulus(2, 1'b1, 8'h02);
    @(posedge clk); #1;
    applyStimulus(2, 1'b1, 8'h01);
    fork
      capture(2, 5, b0, v0, d0, r0);
      begin
        repeat (2) @(posedge clk);
        #1;
        applyStimulus(2, 1'b0, 8'h00);
      end
    join
    checkOutput("w2_b2b_bits", b0, 32'h13);
    checkOutput("w2_b2b_valid", v0, 32'h1E);
    checkOutput("w2_b2b_done", 32'(d0), 32'd2);

    step(2);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
